// File: rtl/rv_branch_resolve_if.sv
// Control-transfer bus between ALU stage 1, fetch redirect and the branch predictor update port.
interface rv_branch_resolve_if #(
    parameter int IADDR_SPACE_BITS = 32
);
    logic                        i_valid;
    logic                        i_inst_jal_jalr;
    logic                        i_inst_branch;
    logic                        i_cmp_true;
    logic                        i_branch_pred;
    logic [IADDR_SPACE_BITS-1:0] i_pc;
    logic [IADDR_SPACE_BITS-1:0] i_pc_next;
    logic [IADDR_SPACE_BITS-1:0] i_pc_target;
    logic                        i_to_trap;
    logic [IADDR_SPACE_BITS-1:0] i_trap_pc;

    logic                        o_redirect;
    logic [IADDR_SPACE_BITS-1:0] o_redirect_pc;
    logic                        o_flush;
    logic                        o_bp_upd_valid;
    logic [IADDR_SPACE_BITS-1:0] o_bp_upd_pc;
    logic                        o_bp_upd_taken;
    logic [IADDR_SPACE_BITS-1:0] o_bp_upd_target;
    logic [31:0]                 o_perf_branches;
    logic [31:0]                 o_perf_mispred;

    // Resolver side.
    modport slave (
        input  i_valid, i_inst_jal_jalr, i_inst_branch, i_cmp_true, i_branch_pred,
               i_pc, i_pc_next, i_pc_target, i_to_trap, i_trap_pc,
        output o_redirect, o_redirect_pc, o_flush, o_bp_upd_valid, o_bp_upd_pc,
               o_bp_upd_taken, o_bp_upd_target, o_perf_branches, o_perf_mispred
    );

    // Pipeline / fetch side.
    modport master (
        output i_valid, i_inst_jal_jalr, i_inst_branch, i_cmp_true, i_branch_pred,
               i_pc, i_pc_next, i_pc_target, i_to_trap, i_trap_pc,
        input  o_redirect, o_redirect_pc, o_flush, o_bp_upd_valid, o_bp_upd_pc,
               o_bp_upd_taken, o_bp_upd_target, o_perf_branches, o_perf_mispred
    );
endinterface

// File: rtl/rv_branch_resolve.sv
// Branch/jump/trap resolution: registered redirect, multi-cycle flush and predictor update.
// Optional BRANCH_PERF_CNT_EN adds saturating resolved-transfer / misprediction counters.
module rv_branch_resolve #(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int FLUSH_CYCLES     = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    rv_branch_resolve_if.slave bus
);
    localparam int AW = IADDR_SPACE_BITS;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;

    logic          resolve, taken, mispred, upd;
    logic [AW-1:0] tgt, seq_pc, actual;

    logic          redirect_q;
    logic [AW-1:0] redirect_pc_q;
    logic          upd_valid_q, upd_taken_q;
    logic [AW-1:0] upd_pc_q, upd_target_q;

    // The predicted direction is already reflected in i_pc_next; the bit is informational.
    logic unused_pred;
    assign unused_pred = bus.i_branch_pred;

    assign resolve = bus.i_valid & (state_q == ST_RUN);
    assign taken   = bus.i_inst_jal_jalr | (bus.i_inst_branch & bus.i_cmp_true);
    assign tgt     = {bus.i_pc_target[AW-1:1], 1'b0};
    assign seq_pc  = bus.i_pc + AW'(4);
    assign actual  = bus.i_to_trap ? bus.i_trap_pc : (taken ? tgt : seq_pc);
    assign mispred = resolve & (bus.i_to_trap | (actual != bus.i_pc_next));
    assign upd     = resolve & (bus.i_inst_branch | bus.i_inst_jal_jalr) & ~bus.i_to_trap;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mispred) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 4'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) state_d = ST_RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_taken_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            redirect_q  <= mispred;
            upd_valid_q <= upd;
            if (mispred) redirect_pc_q <= actual;
            if (upd) begin
                upd_pc_q     <= bus.i_pc;
                upd_taken_q  <= taken;
                upd_target_q <= tgt;
            end
        end
    end

    // Flush follows the FSM directly: FLUSH state spans exactly FLUSH_CYCLES cycles.
    assign bus.o_flush         = (state_q == ST_FLUSH);
    assign bus.o_redirect      = redirect_q;
    assign bus.o_redirect_pc   = redirect_pc_q;
    assign bus.o_bp_upd_valid  = upd_valid_q;
    assign bus.o_bp_upd_pc     = upd_pc_q;
    assign bus.o_bp_upd_taken  = upd_taken_q;
    assign bus.o_bp_upd_target = upd_target_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_mp_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            if (upd && (perf_br_q != 32'hFFFF_FFFF))     perf_br_q <= perf_br_q + 32'd1;
            if (mispred && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_q <= perf_mp_q + 32'd1;
        end
    end

    assign bus.o_perf_branches = perf_br_q;
    assign bus.o_perf_mispred  = perf_mp_q;
`else
    assign bus.o_perf_branches = '0;
    assign bus.o_perf_mispred  = '0;
`endif
endmodule

// File: doc/rv_branch_resolve.md
Name: rv_branch_resolve

Overview:
Consumes the control-transfer outputs of the first ALU stage and resolves each branch, jump or trap. Compares the actual next PC against the PC that fetch followed, and on mismatch issues a registered redirect plus a multi-cycle pipeline flush. Also emits a one-shot branch-predictor update record per resolved control transfer.

Parameters:
IADDR_SPACE_BITS, 32, width of all instruction addresses
FLUSH_CYCLES, 2, cycles o_flush stays high per redirect (1..15)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  stage holds a live instruction this cycle
i_inst_jal_jalr  in  1  JAL/JALR/MRET (unconditional transfer)
i_inst_branch  in  1  conditional branch
i_cmp_true  in  1  branch condition result from ALU
i_branch_pred  in  1  fetch predicted taken
i_pc  in  IADDR_SPACE_BITS  PC of instruction
i_pc_next  in  IADDR_SPACE_BITS  PC fetch actually followed
i_pc_target  in  IADDR_SPACE_BITS  computed target
i_to_trap  in  1  instruction traps
i_trap_pc  in  IADDR_SPACE_BITS  trap vector
o_redirect  out  1  one-cycle redirect strobe to fetch
o_redirect_pc  out  IADDR_SPACE_BITS  new fetch PC
o_flush  out  1  kill younger stages
o_bp_upd_valid  out  1  predictor update strobe
o_bp_upd_pc  out  IADDR_SPACE_BITS  PC of resolved instruction
o_bp_upd_taken  out  1  actual direction
o_bp_upd_target  out  IADDR_SPACE_BITS  actual target
o_perf_branches  out  32  resolved transfers (feature)
o_perf_mispred  out  32  mispredictions (feature)

Behaviour:
- Reset: i_reset sampled at posedge; all outputs 0, state RUN, flush counter 0. Reset mid-flush aborts flush next cycle.
- Resolve condition: i_valid & state==RUN.
- taken = i_inst_jal_jalr | (i_inst_branch & i_cmp_true).
- tgt = i_pc_target with bit 0 forced 0.
- actual = i_to_trap ? i_trap_pc : taken ? tgt : i_pc+4 (mod 2^IADDR_SPACE_BITS, wraps).
- mispred = resolve & (i_to_trap | (actual != i_pc_next)); non-transfer non-trap instructions never mispredict if i_pc_next==i_pc+4, otherwise they do (covers stale prediction on non-branch).
- Trap has priority over branch result when both set.
- Latency 1: on mispred at cycle N, o_redirect=1 and o_redirect_pc=actual at cycle N+1 only; o_flush=1 from N+1 for FLUSH_CYCLES cycles.
- FSM: RUN -> FLUSH on mispred (counter loaded FLUSH_CYCLES-1); FLUSH decrements each cycle, -> RUN when counter==0 and o_flush drops same edge. In FLUSH, i_valid ignored (no resolve, no update, no counting).
- o_redirect_pc holds last value when o_redirect low.
- Predictor update: resolve & (i_inst_branch | i_inst_jal_jalr) & !i_to_trap -> at N+1 o_bp_upd_valid=1 with pc/taken/target (target = tgt regardless of direction). Single-cycle strobe.
- Back-to-back correct resolves in RUN: one update per cycle, no bubbles.

Optional Feature:
BRANCH_PERF_CNT_EN: defined -> o_perf_branches increments on every resolved branch/jump (same qualification as update), o_perf_mispred on every mispred; both saturate at 0xFFFFFFFF, clear on reset, update at N+1. Undefined -> both outputs tied 0, no counter flops.

Test Plan:
- Branch at pc 0x100, cmp_true=1, target 0x140, pc_next 0x140 -> no redirect/flush; o_bp_upd_valid=1, taken=1, target 0x140 next cycle.
- Branch at 0x100 not taken, pc_next 0x140 -> o_redirect=1, redirect_pc 0x104 next cycle; o_flush high exactly 2 cycles; a valid instruction presented during flush produces nothing.
- JALR target 0x201, pc_next 0x104 -> redirect to 0x200, update taken=1 target 0x200.
- Trap (i_to_trap=1, trap_pc 0x80) with taken branch to 0x140 predicted correctly -> redirect 0x80, no update strobe.
- Branch at 0xFFFFFFFC not taken, pc_next 0x0 -> no redirect (wrap); assert i_reset during a flush -> all outputs 0 next cycle, state RUN.
- With BRANCH_PERF_CNT_EN: 3 branches, 1 mispredicted -> perf_branches=3, perf_mispred=1; preloaded at 0xFFFFFFFF stays saturated; without macro both read 0.
